// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the Goldschmidt divider controller and datapath.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE_N = 3'd1,
        PRE_D = 3'd2,
        IT_N  = 3'd3,
        IT_D  = 3'd4,
        DONE  = 3'd5
    } fpdiv_state_t;

    localparam logic [1:0] SEL4_NUM = 2'b00;
    localparam logic [1:0] SEL4_DEN = 2'b01;
    localparam logic [1:0] SEL4_A   = 2'b10;
    localparam logic [1:0] SEL4_B   = 2'b11;

    localparam logic SEL2_IA = 1'b0;
    localparam logic SEL2_C  = 1'b1;

    localparam int FRAC_W = 28;

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset (shared with the fpdiv datapath).
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; reset clears the register.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fpdiv_ctrl.sv
// Sequencing controller for the fpdiv Goldschmidt datapath.
// Optional feature macro: FPDIV_CTRL_STALL_EN adds a 'stall' input that freezes
// the schedule in PRE_N/PRE_D/IT_N/IT_D and masks the register enables.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// PRE_N | A <- N*0.75
// PRE_D | B <- D*0.75, C <- ~B
// IT_N  | A <- A*C (refinement step iter)
// IT_D  | B <- B*C, C <- ~B
// DONE  | quotient mantissa in A, done pulse
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int ITERS = 3
) (
    input  logic        clk,
    input  logic        reset,
`ifdef FPDIV_CTRL_STALL_EN
    input  logic        stall,
`endif
    input  logic        start,
    input  logic [31:0] num_in,
    input  logic [31:0] denom_in,
    output logic        ready,
    output logic [31:0] num_q,
    output logic [31:0] denom_q,
    output logic        sel_mux2,
    output logic [1:0]  sel_mux4,
    output logic        en_a,
    output logic        en_b,
    output logic        busy,
    output logic        done,
    output logic [2:0]  iter
);

    localparam logic [2:0] LP_ITERS = 3'(ITERS);

    if (ITERS < 1 || ITERS > 7) begin : g_iters_check
        $error("fpdiv_ctrl: ITERS must be in 1..7");
    end

    fpdiv_state_t r_state, w_state_nxt;
    logic [2:0]   r_iter, w_iter_nxt;
    logic         w_accept;
    logic         w_stall;

    assign w_accept = start && (r_state == IDLE);

`ifdef FPDIV_CTRL_STALL_EN
    // The enable mask must act in the stalled cycle itself, so this is the one
    // deliberate input-to-output path; without the feature all outputs decode from state.
    assign w_stall = stall && (r_state inside {PRE_N, PRE_D, IT_N, IT_D});
`else
    assign w_stall = 1'b0;
`endif

    // Operand capture on an accepted start; held until the next accepted start.
    flopenr #(.WIDTH(32)) u_num_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_accept),
        .d     (num_in),
        .q     (num_q)
    );

    flopenr #(.WIDTH(32)) u_denom_reg (
        .clk   (clk),
        .reset (reset),
        .en    (w_accept),
        .d     (denom_in),
        .q     (denom_q)
    );

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_iter  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_iter  <= w_iter_nxt;
        end
    end

    // Next-state decode and per-state datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter;
        ready       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        en_a        = 1'b0;
        en_b        = 1'b0;
        sel_mux2    = SEL2_IA;
        sel_mux4    = SEL4_NUM;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start)
                    w_state_nxt = PRE_N;
            end
            PRE_N: begin
                en_a        = 1'b1;
                w_state_nxt = PRE_D;
            end
            PRE_D: begin
                sel_mux4    = SEL4_DEN;
                en_b        = 1'b1;
                w_state_nxt = IT_N;
                w_iter_nxt  = 3'd1;
            end
            IT_N: begin
                sel_mux2 = SEL2_C;
                sel_mux4 = SEL4_A;
                en_a     = 1'b1;
                // Last iteration skips IT_D: its B/C update would never be consumed.
                if (r_iter == LP_ITERS)
                    w_state_nxt = DONE;
                else
                    w_state_nxt = IT_D;
            end
            IT_D: begin
                sel_mux2    = SEL2_C;
                sel_mux4    = SEL4_B;
                en_b        = 1'b1;
                w_state_nxt = IT_N;
                w_iter_nxt  = r_iter + 3'd1;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
                w_iter_nxt  = 3'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_iter_nxt  = 3'd0;
            end
        endcase
        if (w_stall) begin
            w_state_nxt = r_state;
            w_iter_nxt  = r_iter;
            en_a        = 1'b0;
            en_b        = 1'b0;
        end
    end

    assign iter = r_iter;

endmodule
